// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer: channel count,
// select width, dwell counter width and FSM state encodings.
package scan_pkg;

  localparam int NCH   = 8;   // channels in the enable mask
  localparam int CH_W  = 3;   // width of the {a,b,c} select
  localparam int CNT_W = 8;   // dwell counter width, DWELL up to 255

  // State names carry an ST_ prefix so they cannot collide with the
  // DWELL parameter of the top module.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel search: lowest set bit of the mask, and the
// lowest set bit strictly above the current channel index.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] nxt,
  output logic            found,
  output logic [CH_W-1:0] first
);

  // Walk downward so the last hit written is the lowest qualifying bit.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    first = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (CH_W'(i) > cur) begin
          nxt   = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Sequential channel-select generator for the 3-to-8 decoder stage.
// Visits enabled channels of ch_mask in ascending order, holding each
// for DWELL cycles, single-shot or continuous.
// Optional feature macro: SCAN_BLANK_EN inserts one blank cycle
// (next channel shown, sel_valid low) between dwell periods.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic [7:0] ch_mask,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       sel_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  // State entered when a dwell period ends and another channel follows.
`ifdef SCAN_BLANK_EN
  localparam state_t HOP = ST_BLANK;
`else
  localparam state_t HOP = ST_DWELL;
`endif

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CH_W-1:0]   sel, sel_nx;
  logic [NCH-1:0]    mask_q, mask_nx;
  logic              mode_q, mode_nx;

  logic [NCH-1:0]    mask_src;
  logic [CH_W-1:0]   nxt, first;
  logic              found;

  // In IDLE the search looks at the live mask so the first channel is
  // ready on the start edge; mid-scan only the captured copy matters.
  assign mask_src = (state == ST_IDLE) ? ch_mask : mask_q;

  scan_next_ch u_next (
    .mask  (mask_src),
    .cur   (sel),
    .nxt   (nxt),
    .found (found),
    .first (first)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sel    <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel    <= sel_nx;
      mask_q <= mask_nx;
      mode_q <= mode_nx;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    mask_nx  = mask_q;
    mode_nx  = mode_q;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (ch_mask != '0) begin
            mask_nx  = ch_mask;
            mode_nx  = mode_cont;
            sel_nx   = first;
            cnt_nx   = '0;
            state_nx = ST_DWELL;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DWELL: begin
        if (stop) begin
          sel_nx   = '0;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (cnt == LAST) begin
          cnt_nx = '0;
          if (found) begin
            sel_nx   = nxt;
            state_nx = HOP;
          end else if (mode_q) begin
            // Wrap; with a single channel this reloads the same index.
            sel_nx   = first;
            state_nx = HOP;
          end else begin
            // Select holds its last value through DONE.
            state_nx = ST_DONE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (stop) begin
          sel_nx   = '0;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DWELL;
        end
      end
`endif
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decode directly from registered state so an asynchronous
  // reset clears them without waiting for a clock edge.
  always_comb begin
    a         = sel[2];
    b         = sel[1];
    c         = sel[0];
    sel_valid = (state == ST_DWELL);
    busy      = (state == ST_DWELL) || (state == ST_BLANK);
    done      = (state == ST_DONE);
  end

endmodule
